vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_ctrl.sv | 171 +++++++++++++++++
 tb/tb_vend_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-operated vending controller.
// Accepts 25p/50p/Rs1 coins, requests a dispense once credit reaches PRICE,
// then pays out any remainder (or the full credit on cancel) as change.
// Optional build macro VEND_7SEG_EN adds a two-digit 7-segment credit display;
// without it both display outputs are held blank.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no credit held, waiting for the first coin
// COLLECT | credit below PRICE, accepting coins or cancel
// VEND    | dispense requested, waiting for dispense_ack_in
// CHANGE  | change requested, waiting for change_ack_in
module vend_ctrl #(
    parameter int PRICE      = 4,
    parameter int MAX_CREDIT = 12,
    parameter int CREDIT_W   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin_in,
    input  logic                cancel_in,
    input  logic                dispense_ack_in,
    input  logic                change_ack_in,
    output logic                dispense_out,
    output logic                done_out,
    output logic                coin_reject_out,
    output logic                change_valid_out,
    output logic [CREDIT_W-1:0] change_units_out,
    output logic [CREDIT_W-1:0] credit_out,
    output logic [6:0]          lsb7seg_out,
    output logic [6:0]          msb7seg_out
);

    // Sums get three spare bits so credit + Rs1 coin can never wrap.
    localparam int SUM_W = CREDIT_W + 3;

    if (PRICE < 1 || PRICE > MAX_CREDIT || MAX_CREDIT > (2**CREDIT_W) - 1 ||
        MAX_CREDIT > 99) begin : g_param_check
        $error("vend_ctrl: illegal PRICE/MAX_CREDIT/CREDIT_W combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  reject_d, done_d;
    logic                  dispense_q, done_q, reject_q, change_valid_q;
    logic [CREDIT_W-1:0]   change_units_q;
    logic                  coin_valid;
    logic [SUM_W-1:0]      coin_val, credit_sum;

    // Decode the coin code into credit units.
    always_comb begin
        coin_valid = (coin_in != 2'b11);
        case (coin_in)
            2'b00:   coin_val = SUM_W'(1);
            2'b01:   coin_val = SUM_W'(2);
            2'b10:   coin_val = SUM_W'(4);
            default: coin_val = '0;
        endcase
        credit_sum = SUM_W'(credit_q) + coin_val;
    end

    // Next-state, next-credit and pulse decisions for the coming edge.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (state_q == S_COLLECT && cancel_in) begin
                    // Cancel takes priority; a coin in the same cycle is returned.
                    state_d  = S_CHANGE;
                    reject_d = coin_valid;
                end else if (coin_valid) begin
                    if (credit_sum > SUM_W'(MAX_CREDIT)) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = CREDIT_W'(credit_sum);
                        state_d  = (credit_sum >= SUM_W'(PRICE)) ? S_VEND : S_COLLECT;
                    end
                end
            end
            S_VEND: begin
                reject_d = coin_valid;
                if (dispense_ack_in) begin
                    done_d = 1'b1;
                    if (credit_q > CREDIT_W'(PRICE)) begin
                        credit_d = credit_q - CREDIT_W'(PRICE);
                        state_d  = S_CHANGE;
                    end else begin
                        credit_d = '0;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_CHANGE: begin
                reject_d = coin_valid;
                if (change_ack_in) begin
                    credit_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                credit_d = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State, credit and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            dispense_q     <= 1'b0;
            done_q         <= 1'b0;
            reject_q       <= 1'b0;
            change_valid_q <= 1'b0;
            change_units_q <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            dispense_q     <= (state_d == S_VEND);
            done_q         <= done_d;
            reject_q       <= reject_d;
            change_valid_q <= (state_d == S_CHANGE);
            change_units_q <= (state_d == S_CHANGE) ? credit_d : '0;
        end
    end

    assign dispense_out     = dispense_q;
    assign done_out         = done_q;
    assign coin_reject_out  = reject_q;
    assign change_valid_out = change_valid_q;
    assign change_units_out = change_units_q;
    assign credit_out       = credit_q;

`ifdef VEND_7SEG_EN
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Credit never exceeds 99, so seven bits hold it exactly.
    logic [6:0] credit_dec;
    assign credit_dec = 7'(credit_q);

    // Decimal ones/tens digits of the registered credit.
    always_comb begin
        lsb7seg_out = seg_decode(4'(credit_dec % 7'd10));
        msb7seg_out = seg_decode(4'(credit_dec / 7'd10));
    end
`else
    assign lsb7seg_out = 7'b1111111;
    assign msb7seg_out = 7'b1111111;
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: three instances (default, PRICE=6, PRICE=12) share the
// same stimulus; each is compared every cycle with its own behavioural model.
module tb_vend_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] coin  = 2'b11;
    logic       cancel = 1'b0;
    logic       dack = 1'b0;
    logic       cack = 1'b0;

    logic       dispense_w[3];
    logic       done_w[3];
    logic       reject_w[3];
    logic       cvalid_w[3];
    logic [3:0] cunits_w[3];
    logic [3:0] credit_w[3];
    logic [6:0] lsb_w[3];
    logic [6:0] msb_w[3];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    vend_ctrl u_def (
        .clock(clock), .reset(reset), .coin_in(coin), .cancel_in(cancel),
        .dispense_ack_in(dack), .change_ack_in(cack),
        .dispense_out(dispense_w[0]), .done_out(done_w[0]), .coin_reject_out(reject_w[0]),
        .change_valid_out(cvalid_w[0]), .change_units_out(cunits_w[0]),
        .credit_out(credit_w[0]), .lsb7seg_out(lsb_w[0]), .msb7seg_out(msb_w[0]));

    vend_ctrl #(.PRICE(6)) u_p6 (
        .clock(clock), .reset(reset), .coin_in(coin), .cancel_in(cancel),
        .dispense_ack_in(dack), .change_ack_in(cack),
        .dispense_out(dispense_w[1]), .done_out(done_w[1]), .coin_reject_out(reject_w[1]),
        .change_valid_out(cvalid_w[1]), .change_units_out(cunits_w[1]),
        .credit_out(credit_w[1]), .lsb7seg_out(lsb_w[1]), .msb7seg_out(msb_w[1]));

    vend_ctrl #(.PRICE(12), .MAX_CREDIT(12)) u_p12 (
        .clock(clock), .reset(reset), .coin_in(coin), .cancel_in(cancel),
        .dispense_ack_in(dack), .change_ack_in(cack),
        .dispense_out(dispense_w[2]), .done_out(done_w[2]), .coin_reject_out(reject_w[2]),
        .change_valid_out(cvalid_w[2]), .change_units_out(cunits_w[2]),
        .credit_out(credit_w[2]), .lsb7seg_out(lsb_w[2]), .msb7seg_out(msb_w[2]));

    // Behavioural reference: what the machine is doing and how much it holds.
    typedef enum {M_IDLE, M_COLLECT, M_VEND, M_CHANGE} mphase_t;
    int      price[3]  = '{4, 6, 12};
    int      maxc[3]   = '{12, 12, 12};
    mphase_t m_phase[3];
    int      m_credit[3];
    bit      m_rej[3];
    bit      m_done[3];

    function automatic logic [6:0] exp_seg(input int d);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_phase[k] = M_IDLE; m_credit[k] = 0; m_rej[k] = 0; m_done[k] = 0;
        end
    endtask

    task automatic model_step();
        int  value;
        bit  has;
        has   = (coin != 2'b11);
        value = (coin == 2'b00) ? 1 : (coin == 2'b01) ? 2 : (coin == 2'b10) ? 4 : 0;
        for (int k = 0; k < 3; k++) begin
            m_rej[k]  = 0;
            m_done[k] = 0;
            if (m_phase[k] == M_COLLECT && cancel) begin
                m_phase[k] = M_CHANGE;
                m_rej[k]   = has;
            end else if (m_phase[k] == M_IDLE || m_phase[k] == M_COLLECT) begin
                if (has) begin
                    if (m_credit[k] + value > maxc[k]) m_rej[k] = 1;
                    else begin
                        m_credit[k] += value;
                        m_phase[k] = (m_credit[k] >= price[k]) ? M_VEND : M_COLLECT;
                    end
                end
            end else if (m_phase[k] == M_VEND) begin
                m_rej[k] = has;
                if (dack) begin
                    m_done[k] = 1;
                    m_credit[k] -= price[k];
                    m_phase[k] = (m_credit[k] > 0) ? M_CHANGE : M_IDLE;
                end
            end else begin
                m_rej[k] = has;
                if (cack) begin
                    m_credit[k] = 0;
                    m_phase[k] = M_IDLE;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [6:0] el, em;
        for (int k = 0; k < 3; k++) begin
`ifdef VEND_7SEG_EN
            el = exp_seg(m_credit[k] % 10);
            em = exp_seg(m_credit[k] / 10);
`else
            el = 7'h7F;
            em = 7'h7F;
`endif
            check($sformatf("dispense[%0d]", k), 32'(dispense_w[k]), 32'(m_phase[k] == M_VEND));
            check($sformatf("done[%0d]", k), 32'(done_w[k]), 32'(m_done[k]));
            check($sformatf("reject[%0d]", k), 32'(reject_w[k]), 32'(m_rej[k]));
            check($sformatf("change_valid[%0d]", k), 32'(cvalid_w[k]), 32'(m_phase[k] == M_CHANGE));
            if (m_phase[k] == M_CHANGE)
                check($sformatf("change_units[%0d]", k), 32'(cunits_w[k]), 32'(m_credit[k]));
            check($sformatf("credit[%0d]", k), 32'(credit_w[k]), 32'(m_credit[k]));
            check($sformatf("lsb7seg[%0d]", k), 32'(lsb_w[k]), 32'(el));
            check($sformatf("msb7seg[%0d]", k), 32'(msb_w[k]), 32'(em));
        end
    endtask

    task automatic step(input logic [1:0] c, input logic can, input logic da, input logic ca);
        coin = c; cancel = can; dack = da; cack = ca;
        @(posedge clock);
        model_step();
        #1;
        check_all();
        coin = 2'b11; cancel = 1'b0; dack = 1'b0; cack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        // Power-on reset, checked before any clock edge.
        do_reset();
        check("rst_lsb_zero_or_blank", 32'(lsb_w[0]), 32'(exp_seg(0) == 7'h40 ?
`ifdef VEND_7SEG_EN
            7'h40 : 7'h00));
`else
            7'h7F : 7'h00));
`endif

        // 25p, 25p, 50p -> 1, 2, 4 then vend with no change.
        step(2'b00, 0, 0, 0); check("r031_c1", 32'(credit_w[0]), 1);
        step(2'b00, 0, 0, 0); check("r031_c2", 32'(credit_w[0]), 2);
        step(2'b01, 0, 0, 0); check("r031_c4", 32'(credit_w[0]), 4);
        check("r031_disp", 32'(dispense_w[0]), 1);
        step(2'b11, 0, 1, 0); check("r031_done", 32'(done_w[0]), 1);
        check("r031_nochg", 32'(cvalid_w[0]), 0);
        step(2'b11, 0, 0, 0); check("r031_done_drop", 32'(done_w[0]), 0);

        // Coin during VEND is returned.
        do_reset();
        step(2'b10, 0, 0, 0); check("r032_disp", 32'(dispense_w[0]), 1);
        step(2'b01, 0, 0, 0); check("r032_rej", 32'(reject_w[0]), 1);
        check("r032_credit", 32'(credit_w[0]), 4);
        step(2'b11, 0, 1, 0); check("r032_credit0", 32'(credit_w[0]), 0);

        // PRICE=6: Rs1 + Rs1 -> 8, vend, 2 units change.
        do_reset();
        step(2'b10, 0, 0, 0);
        step(2'b10, 0, 0, 0); check("r033_credit8", 32'(credit_w[1]), 8);
        step(2'b11, 0, 1, 0); check("r033_units", 32'(cunits_w[1]), 2);
        check("r033_cvalid", 32'(cvalid_w[1]), 1);
        step(2'b11, 0, 0, 1); check("r033_cvalid_drop", 32'(cvalid_w[1]), 0);

        // Cancel with a coin in the same cycle.
        do_reset();
        step(2'b01, 0, 0, 0);
        step(2'b00, 1, 0, 0); check("r034_rej", 32'(reject_w[0]), 1);
        check("r034_units", 32'(cunits_w[0]), 2);

        // PRICE=MAX=12: fill to the ceiling, last coin returned.
        do_reset();
        step(2'b10, 0, 0, 0);
        step(2'b10, 0, 0, 0);
        step(2'b10, 0, 0, 0);
        step(2'b00, 0, 0, 0); check("r035_rej", 32'(reject_w[2]), 1);
        check("r035_credit", 32'(credit_w[2]), 12);
`ifdef VEND_7SEG_EN
        check("r035_lsb", 32'(lsb_w[2]), 32'(7'b0100100));
        check("r035_msb", 32'(msb_w[2]), 32'(7'b1111001));
`endif

        // Asynchronous reset in the middle of CHANGE.
        do_reset();
        step(2'b10, 0, 0, 0);
        step(2'b10, 0, 0, 0);
        step(2'b11, 0, 1, 0); check("r036_in_change", 32'(cvalid_w[1]), 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("r036_cvalid", 32'(cvalid_w[1]), 0);
        check("r036_units", 32'(cunits_w[1]), 0);
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] c;
            c = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) c = 2'b11;
            step(c, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
